fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It owns the program counter, issues requests to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register consumed by decode and `Control_Unit`. It accepts branch/jump redirects (`pc_select`/`pc_target`) from the stage carrying the control-unit outputs, plus stall and flush from the hazard unit. A one-entry skid buffer and a drain state keep the memory handshake legal across stalls and redirects.

---
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// A transfer completes on any rising edge where req && ready.
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic [31:0]     rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the imem handshake and loads IF/ID.
// A one-entry skid buffer (HOLD) and a drain state (DRAIN) keep requests legal across stalls and redirects.
module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                reset,
   fetch_stage_if.master       imem,
   input  logic                pc_select,
   input  logic [XLEN-1:0]     pc_target,
   input  logic                stall,
   input  logic                flush,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instr,
   output logic [XLEN-1:0]     if_id_pc,
   output logic [XLEN-1:0]     if_id_pc_plus4
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] PC_INC     = XLEN'(32'd4);
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] drain_addr_q, drain_addr_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic            if_id_valid_q, if_id_valid_d;
   logic [31:0]     if_id_instr_q, if_id_instr_d;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;

   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] pc_plus4_s;
   logic            load_req_s;
   logic            load_skid_s;

   assign target_s   = pc_target & ALIGN_MASK;
   assign pc_plus4_s = pc_q + PC_INC;

   assign imem.req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
   assign imem.addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

   assign if_id_valid    = if_id_valid_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc       = if_id_pc_q;
   assign if_id_pc_plus4 = if_id_pc_plus4_q;

   // FSM next state, PC, drain address and skid buffer; redirect outranks everything
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      load_req_s   = 1'b0;
      load_skid_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (pc_select) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_REQ: begin
            if (pc_select) begin
               pc_d = target_s;
               if (!imem.ready) begin
                  // the outstanding request must finish at its original address
                  drain_addr_d = pc_q;
                  state_d      = ST_DRAIN;
               end else begin
                  state_d = ST_REQ;
               end
            end else if (imem.ready) begin
               pc_d = pc_plus4_s;
               if (!stall || flush) begin
                  load_req_s = 1'b1;
               end else begin
                  skid_instr_d = imem.rdata;
                  skid_pc_d    = pc_q;
                  state_d      = ST_HOLD;
               end
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (pc_select) begin
               pc_d = target_s;
            end else if (imem.ready) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (pc_select) begin
               pc_d         = target_s;
               skid_instr_d = 32'h0000_0000;
               skid_pc_d    = '0;
               state_d      = ST_REQ;
            end else if (!stall && !flush) begin
               load_skid_s = 1'b1;
               state_d     = ST_REQ;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // IF/ID update: redirect > load > flush > stall hold > bubble
   always_comb begin
      if_id_valid_d    = if_id_valid_q;
      if_id_instr_d    = if_id_instr_q;
      if_id_pc_d       = if_id_pc_q;
      if_id_pc_plus4_d = if_id_pc_plus4_q;
      if (pc_select) begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
      end else if (load_req_s) begin
         if_id_valid_d    = 1'b1;
         if_id_instr_d    = imem.rdata;
         if_id_pc_d       = pc_q;
         if_id_pc_plus4_d = pc_plus4_s;
      end else if (load_skid_s) begin
         if_id_valid_d    = 1'b1;
         if_id_instr_d    = skid_instr_q;
         if_id_pc_d       = skid_pc_q;
         if_id_pc_plus4_d = skid_pc_q + PC_INC;
      end else if (flush || !stall) begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
      end else begin
         if_id_valid_d = if_id_valid_q;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         pc_q             <= RESET_PC;
         drain_addr_q     <= '0;
         skid_instr_q     <= 32'h0000_0000;
         skid_pc_q        <= '0;
         if_id_valid_q    <= 1'b0;
         if_id_instr_q    <= NOP_INSTR;
         if_id_pc_q       <= '0;
         if_id_pc_plus4_q <= '0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         drain_addr_q     <= drain_addr_d;
         skid_instr_q     <= skid_instr_d;
         skid_pc_q        <= skid_pc_d;
         if_id_valid_q    <= if_id_valid_d;
         if_id_instr_q    <= if_id_instr_d;
         if_id_pc_q       <= if_id_pc_d;
         if_id_pc_plus4_q <= if_id_pc_plus4_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr ^ 0xC0DE0000 while ready is high.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_select;
   logic [31:0] pc_target;
   logic        stall;
   logic        flush;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;

   int vectors = 0;
   int miscompares = 0;

   fetch_stage_if #(.XLEN(32)) bus ();

   assign bus.rdata = bus.ready ? (bus.addr ^ 32'hC0DE_0000) : 32'h0000_0000;

   fetch_stage #(
      .XLEN(32),
      .RESET_PC(32'h0000_0000),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .clk(clk),
      .reset(reset),
      .imem(bus),
      .pc_select(pc_select),
      .pc_target(pc_target),
      .stall(stall),
      .flush(flush),
      .if_id_valid(if_id_valid),
      .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // checks a valid IF/ID entry for address a plus the current request
   task automatic chk_ifid(input string tag, input logic [31:0] a, input logic [31:0] next_addr);
      chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
      chk({tag, "_pc"}, if_id_pc, a);
      chk({tag, "_pc4"}, if_id_pc_plus4, a + 32'd4);
      chk({tag, "_instr"}, if_id_instr, a ^ 32'hC0DE_0000);
      chk({tag, "_req"}, {31'd0, bus.req}, 32'd1);
      chk({tag, "_addr"}, bus.addr, next_addr);
   endtask

   initial begin
      reset = 1'b1; bus.ready = 1'b1; pc_select = 1'b0; pc_target = 32'd0;
      stall = 1'b0; flush = 1'b0;
      tick(); tick();
      chk("rst_req", {31'd0, bus.req}, 32'd0);
      chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst_instr", if_id_instr, 32'h0000_0013);
      chk("rst_pc", if_id_pc, 32'd0);
      chk("rst_pc4", if_id_pc_plus4, 32'd0);

      reset = 1'b0;
      chk("idle_req", {31'd0, bus.req}, 32'd0);
      tick();
      chk("first_req", {31'd0, bus.req}, 32'd1);
      chk("first_addr", bus.addr, 32'h0);
      tick(); chk_ifid("seq0", 32'h0, 32'h4);
      tick(); chk_ifid("seq4", 32'h4, 32'h8);

      // wait states at 0x8
      bus.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_addr", bus.addr, 32'h8);
         chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
      end
      bus.ready = 1'b1;
      tick(); chk_ifid("seq8", 32'h8, 32'hC);

      // stall on accept of 0xC for two edges
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("hold_req", {31'd0, bus.req}, 32'd0);
         chk("hold_pc", if_id_pc, 32'h8);
         chk("hold_valid", {31'd0, if_id_valid}, 32'd1);
      end
      stall = 1'b0;
      tick(); chk_ifid("skidC", 32'hC, 32'h10);

      // redirect while waiting at 0x10
      bus.ready = 1'b0; pc_select = 1'b1; pc_target = 32'h102;
      tick();
      chk("drain_addr", bus.addr, 32'h10);
      chk("drain_req", {31'd0, bus.req}, 32'd1);
      chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
      pc_select = 1'b0;
      tick();
      chk("drain_addr2", bus.addr, 32'h10);
      chk("drain_valid2", {31'd0, if_id_valid}, 32'd0);
      bus.ready = 1'b1;
      tick();
      chk("post_drain_addr", bus.addr, 32'h100);
      chk("post_drain_valid", {31'd0, if_id_valid}, 32'd0);
      tick(); chk_ifid("tgt100", 32'h100, 32'h104);

      // redirect coinciding with ready
      pc_select = 1'b1; pc_target = 32'h200;
      tick();
      chk("redir_rdy_valid", {31'd0, if_id_valid}, 32'd0);
      chk("redir_rdy_addr", bus.addr, 32'h200);
      pc_select = 1'b0;
      tick(); chk_ifid("tgt200", 32'h200, 32'h204);

      // redirect in HOLD discards skid (0x204)
      stall = 1'b1;
      tick();
      chk("hold2_req", {31'd0, bus.req}, 32'd0);
      chk("hold2_pc", if_id_pc, 32'h200);
      pc_select = 1'b1; pc_target = 32'h300;
      tick();
      chk("redir_hold_valid", {31'd0, if_id_valid}, 32'd0);
      chk("redir_hold_instr", if_id_instr, 32'h0000_0013);
      chk("redir_hold_addr", bus.addr, 32'h300);
      pc_select = 1'b0; stall = 1'b0;
      tick(); chk_ifid("tgt300", 32'h300, 32'h304);

      // flush with stall, no accept
      bus.ready = 1'b0; stall = 1'b1; flush = 1'b1;
      tick();
      chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
      chk("flush_instr", if_id_instr, 32'h0000_0013);
      chk("flush_addr", bus.addr, 32'h304);
      stall = 1'b0; flush = 1'b0; bus.ready = 1'b1;

      // wrap-around
      pc_select = 1'b1; pc_target = 32'hFFFF_FFF8;
      tick();
      chk("wrap_addr", bus.addr, 32'hFFFF_FFF8);
      pc_select = 1'b0;
      tick(); chk_ifid("wrapF8", 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      tick(); chk_ifid("wrapFC", 32'hFFFF_FFFC, 32'h0);

      // flush coinciding with accept still loads the new instruction
      flush = 1'b1; stall = 1'b1;
      tick(); chk_ifid("flush_acc", 32'h0, 32'h4);
      flush = 1'b0; stall = 1'b0;

      // asynchronous reset mid-transfer
      bus.ready = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("arst_req", {31'd0, bus.req}, 32'd0);
      chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("arst_instr", if_id_instr, 32'h0000_0013);
      tick();
      reset = 1'b0; bus.ready = 1'b1;
      tick();
      chk("rerun_addr", bus.addr, 32'h0);
      tick(); chk_ifid("rerun0", 32'h0, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
